// File: rtl/pe_comb_pkg.sv
// Shared sizing and phase constants for the 5x5 output-stationary systolic array.
// Phase boundaries are expressed as counter values so the top and bench agree.
package pe_comb_pkg;

   localparam int DW             = 8;
   localparam int N              = 5;
   localparam int COMPUTE_CYCLES = 13;
   localparam int DRAIN_CYCLES   = 5;
   localparam int CNT_MAX        = COMPUTE_CYCLES + DRAIN_CYCLES;
   localparam int CNT_W          = $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   // Phase decode from the edge counter value seen at a clock edge.
   function automatic logic is_compute(input cnt_t c);
      return c < cnt_t'(COMPUTE_CYCLES);
   endfunction

   function automatic logic is_drain(input cnt_t c);
      return (c >= cnt_t'(COMPUTE_CYCLES)) && (c < cnt_t'(CNT_MAX));
   endfunction

endpackage

// File: rtl/pe_comb_mac_pe.sv
// One processing element: forwards operands right/down and accumulates
// their wrapped unsigned product while enabled; frozen otherwise.
module mac_pe #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic          en,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out,
   output logic [DW-1:0] acc
);

   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] w_prod;

   // Low DW bits only: product and sum both wrap mod 2^DW.
   assign w_prod = a_in * b_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (en) begin
         r_a   <= a_in;
         r_b   <= b_in;
         r_acc <= r_acc + w_prod;
      end
   end

   assign a_out = r_a;
   assign b_out = r_b;
   assign acc   = r_acc;

endmodule

// File: rtl/pe_comb.sv
// 5x5 systolic matrix multiplier: 13 compute edges, then five registered
// row drains, then idle with zero outputs until the next reset.
module pe_comb #(
   parameter int DW = 8,
   parameter int N  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] a1,
   input  logic [DW-1:0] a2,
   input  logic [DW-1:0] a3,
   input  logic [DW-1:0] a4,
   input  logic [DW-1:0] a5,
   input  logic [DW-1:0] b1,
   input  logic [DW-1:0] b2,
   input  logic [DW-1:0] b3,
   input  logic [DW-1:0] b4,
   input  logic [DW-1:0] b5,
   output logic [DW-1:0] d_a,
   output logic [DW-1:0] d_b,
   output logic [DW-1:0] d_c,
   output logic [DW-1:0] d_d,
   output logic [DW-1:0] d_e
);
   import pe_comb_pkg::*;

   cnt_t          r_cnt;
   logic          w_en;
   logic          w_drain;
   logic [2:0]    w_row;
   logic [DW-1:0] w_a_edge [N];
   logic [DW-1:0] w_b_edge [N];
   logic [DW-1:0] w_a_q    [N][N];
   logic [DW-1:0] w_b_q    [N][N];
   logic [DW-1:0] w_acc    [N][N];
   logic [DW-1:0] w_sel    [N];
   logic [DW-1:0] r_d      [N];

   assign w_a_edge[0] = a1;
   assign w_a_edge[1] = a2;
   assign w_a_edge[2] = a3;
   assign w_a_edge[3] = a4;
   assign w_a_edge[4] = a5;
   assign w_b_edge[0] = b1;
   assign w_b_edge[1] = b2;
   assign w_b_edge[2] = b3;
   assign w_b_edge[3] = b4;
   assign w_b_edge[4] = b5;

   // r_cnt holds the index of the upcoming edge; it parks at CNT_MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (r_cnt != cnt_t'(CNT_MAX))
         r_cnt <= r_cnt + 1'b1;
   end

   assign w_en    = is_compute(r_cnt);
   assign w_drain = is_drain(r_cnt);
   assign w_row   = 3'(r_cnt - cnt_t'(COMPUTE_CYCLES));

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [DW-1:0] w_ain;
         logic [DW-1:0] w_bin;

         if (j == 0) begin : g_aedge
            assign w_ain = w_a_edge[i];
         end else begin : g_ainner
            assign w_ain = w_a_q[i][j-1];
         end

         if (i == 0) begin : g_bedge
            assign w_bin = w_b_edge[j];
         end else begin : g_binner
            assign w_bin = w_b_q[i-1][j];
         end

         mac_pe #(.DW(DW)) u_pe (
            .clk  (clk),
            .rst  (rst),
            .a_in (w_ain),
            .b_in (w_bin),
            .en   (w_en),
            .a_out(w_a_q[i][j]),
            .b_out(w_b_q[i][j]),
            .acc  (w_acc[i][j])
         );
      end
   end

   always_comb begin
      for (int c = 0; c < N; c++) begin
         w_sel[c] = '0;
         if (w_drain)
            w_sel[c] = w_acc[w_row][c];
      end
   end

   // Zero outside the drain window covers both compute and idle phases.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N; c++)
            r_d[c] <= '0;
      end else begin
         for (int c = 0; c < N; c++)
            r_d[c] <= w_sel[c];
      end
   end

   assign d_a = r_d[0];
   assign d_b = r_d[1];
   assign d_c = r_d[2];
   assign d_d = r_d[3];
   assign d_e = r_d[4];

endmodule

// File: tb/tb_pe_comb.sv
// Directed bench for pe_comb: skewed operand feed, per-edge expected drain
// values queued from a plain matrix-product model, async-reset abort cases.
module tb_pe_comb;

   logic       clk;
   logic       rst;
   logic [7:0] av [5];
   logic [7:0] bv [5];
   logic [7:0] d_a, d_b, d_c, d_d, d_e;

   int         A [5][5];
   int         B [5][5];
   int         C [5][5];
   logic [39:0] sb [$];
   int         n_cmp;
   int         n_bad;

   pe_comb #(.DW(8), .N(5)) dut (
      .clk(clk), .rst(rst),
      .a1(av[0]), .a2(av[1]), .a3(av[2]), .a4(av[3]), .a5(av[4]),
      .b1(bv[0]), .b2(bv[1]), .b3(bv[2]), .b4(bv[3]), .b5(bv[4]),
      .d_a(d_a), .d_b(d_b), .d_c(d_c), .d_d(d_d), .d_e(d_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [39:0] obs();
      return {d_a, d_b, d_c, d_d, d_e};
   endfunction

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic fill(input int fa, input int fb, input int mode);
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            case (mode)
               0: begin A[i][j] = (i == j) ? 1 : 0; B[i][j] = 5 * i + j + 1; end
               1: begin A[i][j] = fa; B[i][j] = fb; end
               default: begin A[i][j] = $urandom_range(0, 255); B[i][j] = $urandom_range(0, 255); end
            endcase
         end
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            C[i][j] = 0;
            for (int k = 0; k < 5; k++)
               C[i][j] = (C[i][j] + A[i][k] * B[k][j]) % 256;
         end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin av[i] = 8'hFF; bv[i] = 8'hFF; end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Starts on a negedge with rst low; the next posedge is edge cnt=0.
   // abort_at >= 0 asserts rst right after that edge and returns.
   task automatic run(input string tag, input int last_t, input int abort_at);
      logic [39:0] e;
      for (int t = 0; t <= last_t; t++) begin
         for (int i = 0; i < 5; i++) begin
            av[i] = (t - i >= 0 && t - i < 5) ? 8'(A[i][t-i]) : 8'h00;
            bv[i] = (t - i >= 0 && t - i < 5) ? 8'(B[t-i][i]) : 8'h00;
         end
         e = '0;
         if (t >= 13 && t <= 17)
            e = {8'(C[t-13][0]), 8'(C[t-13][1]), 8'(C[t-13][2]),
                 8'(C[t-13][3]), 8'(C[t-13][4])};
         sb.push_back(e);
         @(posedge clk);
         #1;
         check($sformatf("%s_cnt%0d", tag, t), obs(), sb.pop_front());
         if (t == abort_at) begin
            rst = 1'b1;
            #1;
            check($sformatf("%s_abort_clear", tag), obs(), 40'h0);
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin av[i] = '0; bv[i] = '0; end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_state", obs(), 40'h0);

      do_reset();
      fill(0, 0, 0);
      run("ident", 22, -1);

      do_reset();
      fill(1, 1, 1);
      run("ones", 20, -1);

      do_reset();
      fill(2, 3, 1);
      run("two_three", 20, -1);

      do_reset();
      fill(15, 15, 1);
      run("wrap15", 20, -1);

      // Abort mid-compute, then all-ones with no extra reset.
      do_reset();
      fill(0, 0, 0);
      run("abort_comp", 20, 6);
      fill(1, 1, 1);
      run("after_comp_abort", 20, -1);

      // Abort mid-drain while outputs are nonzero.
      do_reset();
      fill(15, 15, 1);
      run("abort_drain", 20, 14);
      fill(0, 0, 2);
      run("after_drain_abort", 24, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
